// File: rtl/dp_memory.sv
// Dual-port byte-enabled memory with a self-clearing sweep after reset or init_req.
// Optional per-lane even parity and a par_err output when DP_MEMORY_PARITY_EN is defined.
module dp_memory #(
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned RD_MODE    = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    init_req,
  output logic                    busy,
  input  logic                    we,
  input  logic [DATA_WIDTH/8-1:0] wbe,
  input  logic [ADDR_WIDTH-1:0]   waddr,
  input  logic [DATA_WIDTH-1:0]   wrdata,
  input  logic                    re,
  input  logic [ADDR_WIDTH-1:0]   raddr,
  output logic [DATA_WIDTH-1:0]   rddata,
  output logic                    rvalid,
  output logic                    addr_err
`ifdef DP_MEMORY_PARITY_EN
  ,
  output logic                    par_err
`endif
);

  localparam int unsigned NB = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0]   DepthW   = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [0:0] {StClear, StIdle} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   sweep_q, sweep_d;
  logic [DATA_WIDTH-1:0]   rddata_q, rddata_d;
  logic                    rvalid_q, rvalid_d;
  logic                    addr_err_q, addr_err_d;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  logic                    waddr_ok, raddr_ok, clr_en, wr_en, fwd;
  logic [DATA_WIDTH-1:0]   wmask, old_word, merged_word, rd_word;

  assign waddr_ok = {1'b0, waddr} < DepthW;
  assign raddr_ok = {1'b0, raddr} < DepthW;
  assign clr_en   = (state_q == StClear);
  assign wr_en    = (state_q == StIdle) && we && waddr_ok;
  // Write-first forwarding only matters on a true same-address collision.
  assign fwd      = (RD_MODE == 1) && wr_en && (waddr == raddr);

  always_comb begin
    wmask = '0;
    for (int k = 0; k < NB; k++) begin
      wmask[8*k +: 8] = {8{wbe[k]}};
    end
  end

  assign old_word    = raddr_ok ? mem_q[raddr] : '0;
  assign merged_word = (old_word & ~wmask) | (wrdata & wmask);
  assign rd_word     = fwd ? merged_word : old_word;

  always_comb begin
    state_d    = state_q;
    sweep_d    = sweep_q;
    rddata_d   = rddata_q;
    rvalid_d   = 1'b0;
    addr_err_d = 1'b0;
    unique case (state_q)
      StClear: begin
        sweep_d = sweep_q + 1'b1;
        if (sweep_q == LastAddr) begin
          state_d = StIdle;
          sweep_d = '0;
        end
      end
      StIdle: begin
        if (init_req) begin
          state_d = StClear;
          sweep_d = '0;
        end
        if (re) begin
          rvalid_d = 1'b1;
          rddata_d = raddr_ok ? rd_word : '0;
        end
        addr_err_d = (we && !waddr_ok) || (re && !raddr_ok);
      end
      default: state_d = StClear;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StClear;
      sweep_q    <= '0;
      rddata_q   <= '0;
      rvalid_q   <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sweep_q    <= sweep_d;
      rddata_q   <= rddata_d;
      rvalid_q   <= rvalid_d;
      addr_err_q <= addr_err_d;
    end
  end

  // Storage has no reset; the sweep that follows reset zeroes it.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (clr_en) begin
        mem_q[sweep_q] <= '0;
      end else if (wr_en) begin
        for (int k = 0; k < NB; k++) begin
          if (wbe[k]) mem_q[waddr][8*k +: 8] <= wrdata[8*k +: 8];
        end
      end
    end
  end

  assign busy     = (state_q == StClear);
  assign rddata   = rddata_q;
  assign rvalid   = rvalid_q;
  assign addr_err = addr_err_q;

`ifdef DP_MEMORY_PARITY_EN
  logic [NB-1:0] par_mem_q [DEPTH];
  logic [NB-1:0] wr_par, old_par, rd_par, calc_par;
  logic          par_err_q, par_err_d;

  always_comb begin
    for (int k = 0; k < NB; k++) begin
      wr_par[k]   = ^wrdata[8*k +: 8];
      calc_par[k] = ^rd_word[8*k +: 8];
    end
  end

  assign old_par   = raddr_ok ? par_mem_q[raddr] : '0;
  assign rd_par    = fwd ? ((old_par & ~wbe) | (wr_par & wbe)) : old_par;
  assign par_err_d = (state_q == StIdle) && re && raddr_ok && |(calc_par ^ rd_par);

  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (clr_en) begin
        par_mem_q[sweep_q] <= '0;
      end else if (wr_en) begin
        for (int k = 0; k < NB; k++) begin
          if (wbe[k]) par_mem_q[waddr][k] <= wr_par[k];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) par_err_q <= 1'b0;
    else        par_err_q <= par_err_d;
  end

  assign par_err = par_err_q;
`endif

endmodule

// File: tb/tb_dp_memory.sv
// Randomized scoreboard bench for dp_memory: read-first and write-first instances share stimulus.
// Parity checks are compiled in when DP_MEMORY_PARITY_EN is defined.
module tb_dp_memory;

  localparam int unsigned AW  = 3;
  localparam int unsigned DW  = 16;
  localparam int unsigned DEP = 6;

  logic          clk = 1'b0;
  logic          rst_n, init_req, we, re;
  logic [1:0]    wbe;
  logic [AW-1:0] waddr, raddr;
  logic [DW-1:0] wrdata;
  logic [DW-1:0] rddata0, rddata1;
  logic          rvalid0, rvalid1, addr_err0, addr_err1, busy0, busy1;
  logic          par_err0, par_err1;

  always #5 clk = ~clk;

  dp_memory #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEP), .RD_MODE(0)) u_rf (
    .clk(clk), .rst_n(rst_n), .init_req(init_req), .busy(busy0), .we(we), .wbe(wbe),
    .waddr(waddr), .wrdata(wrdata), .re(re), .raddr(raddr), .rddata(rddata0),
    .rvalid(rvalid0), .addr_err(addr_err0)
`ifdef DP_MEMORY_PARITY_EN
    , .par_err(par_err0)
`endif
  );

  dp_memory #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEP), .RD_MODE(1)) u_wf (
    .clk(clk), .rst_n(rst_n), .init_req(init_req), .busy(busy1), .we(we), .wbe(wbe),
    .waddr(waddr), .wrdata(wrdata), .re(re), .raddr(raddr), .rddata(rddata1),
    .rvalid(rvalid1), .addr_err(addr_err1)
`ifdef DP_MEMORY_PARITY_EN
    , .par_err(par_err1)
`endif
  );

`ifndef DP_MEMORY_PARITY_EN
  assign par_err0 = 1'b0;
  assign par_err1 = 1'b0;
`endif

  typedef struct {
    logic          rv;
    logic          err;
    logic          par;
    logic [DW-1:0] d0;
    logic [DW-1:0] d1;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          e;
  int            n_checks = 0;
  int            n_fails  = 0;
  bit            rst_seen = 1'b0;
  int            clear_left = 0;
  logic [DW-1:0] model_mem [8];
  bit            flipped [8];
  logic [DW-1:0] hold0 = '0, hold1 = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_clear();
    for (int a = 0; a < 8; a++) begin
      model_mem[a] = '0;
      flipped[a]   = 1'b0;
    end
  endtask

  // Drives one cycle, predicts the response from the array model, then advances.
  task automatic do_cycle(input bit iw, input logic [1:0] iwbe, input int iwa,
                          input logic [DW-1:0] iwd, input bit ir, input int ira, input bit iinit);
    logic [DW-1:0] mask, old, merged;
    bit werr, rerr;
    exp_t x;
    we = iw; wbe = iwbe; waddr = AW'(iwa); wrdata = iwd; re = ir; raddr = AW'(ira);
    init_req = iinit;
    check("busy_rf", 32'(busy0), 32'(clear_left > 0));
    check("busy_wf", 32'(busy1), 32'(clear_left > 0));
    if (clear_left > 0) begin
      clear_left--;
      if (clear_left == 0) model_clear();
    end else begin
      mask   = {{8{iwbe[1]}}, {8{iwbe[0]}}};
      werr   = iw && (iwa >= DEP);
      rerr   = ir && (ira >= DEP);
      old    = rerr ? '0 : model_mem[ira];
      merged = (iw && !werr && iwa == ira) ? ((old & ~mask) | (iwd & mask)) : old;
      if (ir || werr || rerr) begin
        x.rv  = ir;
        x.err = werr || rerr;
        x.par = ir && !rerr && flipped[ira];
        x.d0  = old;
        x.d1  = merged;
        exp_q.push_back(x);
      end
      if (iw && !werr) begin
        model_mem[iwa] = (model_mem[iwa] & ~mask) | (iwd & mask);
        if (iwbe[0]) flipped[iwa] = 1'b0;
      end
      if (iinit) clear_left = DEP;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) do_cycle(0, 2'b00, 0, '0, 0, 0, 0);
  endtask

  task automatic wr(input int a, input logic [DW-1:0] d, input logic [1:0] be);
    do_cycle(1, be, a, d, 0, 0, 0);
  endtask

  task automatic rd(input int a);
    do_cycle(0, 2'b00, 0, '0, 1, a, 0);
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0; we = 1'b0; re = 1'b0; init_req = 1'b0;
    wbe = '0; waddr = '0; raddr = '0; wrdata = '0;
    @(posedge clk);
    #1;
    rst_seen = 1'b1;
    check("rst_busy", 32'(busy0 & busy1), 32'd1);
    check("rst_rvalid", 32'(rvalid0 | rvalid1), 32'd0);
    check("rst_addr_err", 32'(addr_err0 | addr_err1), 32'd0);
    check("rst_rddata", 32'(rddata0 | rddata1), 32'd0);
    for (int i = 1; i < n; i++) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
    clear_left = DEP;
    model_clear();
  endtask

  // Monitor: pops one expectation per cycle in which either instance presents output.
  always @(negedge clk) begin
    if (rst_seen) begin
      if (rvalid0 | rvalid1 | addr_err0 | addr_err1 | par_err0 | par_err1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("rvalid_rf", 32'(rvalid0), 32'(e.rv));
          check("rvalid_wf", 32'(rvalid1), 32'(e.rv));
          check("addr_err_rf", 32'(addr_err0), 32'(e.err));
          check("addr_err_wf", 32'(addr_err1), 32'(e.err));
`ifdef DP_MEMORY_PARITY_EN
          check("par_err_rf", 32'(par_err0), 32'(e.par));
          check("par_err_wf", 32'(par_err1), 32'(e.par));
`endif
          if (e.rv) begin
            check("rddata_rf", 32'(rddata0), 32'(e.d0));
            check("rddata_wf", 32'(rddata1), 32'(e.d1));
            hold0 = e.d0;
            hold1 = e.d1;
          end else begin
            check("rddata_hold_rf", 32'(rddata0), 32'(hold0));
            check("rddata_hold_wf", 32'(rddata1), 32'(hold1));
          end
        end
      end else begin
        check("rddata_hold_rf", 32'(rddata0), 32'(hold0));
        check("rddata_hold_wf", 32'(rddata1), 32'(hold1));
      end
      if (!rst_n) begin
        hold0 = '0;
        hold1 = '0;
      end
    end
  end

  initial begin
    rst_n = 1'b0; init_req = 1'b0; we = 1'b0; re = 1'b0;
    wbe = '0; waddr = '0; raddr = '0; wrdata = '0;
    model_clear();

    // Reset, busy for exactly DEP cycles, then the whole array reads zero.
    do_reset(3);
    idle(DEP + 1);
    for (int a = 0; a < DEP; a++) rd(a);

    // Byte-lane merge: ABCD then 1234 on lane 0 only -> AB34.
    wr(2, 16'hABCD, 2'b11);
    wr(2, 16'h1234, 2'b01);
    wr(2, 16'hFFFF, 2'b00);
    rd(2);

    // Same-address collision: read-first sees 0011, write-first sees 0055.
    wr(5, 16'h0011, 2'b11);
    do_cycle(1, 2'b11, 5, 16'h0055, 1, 5, 0);
    rd(5);

    // Out-of-range accesses, including a simultaneous write and read error.
    wr(7, 16'hDEAD, 2'b11);
    rd(7);
    do_cycle(1, 2'b11, 6, 16'hBEEF, 1, 7, 0);
    rd(6 - 5);

    // init_req clear: accesses during busy are ignored.
    do_cycle(0, 2'b00, 0, '0, 0, 0, 1);
    for (int i = 0; i < DEP; i++) do_cycle(1, 2'b11, i, 16'h5A5A, 1, i, 1);
    idle(1);
    rd(2);
    rd(5);

    // Reset mid-sweep restarts the full clear.
    wr(3, 16'h7777, 2'b11);
    do_cycle(0, 2'b00, 0, '0, 0, 0, 1);
    idle(2);
    do_reset(1);
    idle(DEP + 1);
    rd(3);

    // Randomized traffic, with occasional re-initialisation.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        do_cycle(0, 2'b00, 0, '0, 0, 0, 1);
      end else begin
        do_cycle(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
                 DW'($urandom), 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), 0);
      end
    end
    idle(DEP + 1);

`ifdef DP_MEMORY_PARITY_EN
    wr(3, 16'h00F0, 2'b11);
    rd(3);
    u_rf.mem_q[3][0] = ~u_rf.mem_q[3][0];
    u_wf.mem_q[3][0] = ~u_wf.mem_q[3][0];
    model_mem[3][0] = ~model_mem[3][0];
    flipped[3] = 1'b1;
    rd(3);
    rd(4);
`endif

    idle(3);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dp_memory.md
DP_MEMORY -- requirements
Module: dp_memory

Interface
REQ-001 Parameter ADDR_WIDTH, default 3: width of waddr and raddr.
REQ-002 Parameter DATA_WIDTH, default 8: word width; SHALL be a multiple of 8; NB = DATA_WIDTH/8 byte lanes.
REQ-003 Parameter DEPTH, default 8: number of words; SHALL satisfy 1 <= DEPTH <= 2**ADDR_WIDTH.
REQ-004 Parameter RD_MODE, default 0: 0 = read-first, 1 = write-first on a same-address read/write collision.
REQ-005 clk  input  1  single clock; all logic on the rising edge.
REQ-006 rst_n  input  1  reset; synchronous, active-low.
REQ-007 init_req  input  1  pulse; starts a full-array clear when idle.
REQ-008 busy  output  1  high while a clear sweep runs.
REQ-009 we  input  1  write enable.
REQ-010 wbe  input  NB  byte-lane write enables; bit k covers wrdata[8k+7:8k].
REQ-011 waddr  input  ADDR_WIDTH  write address.
REQ-012 wrdata  input  DATA_WIDTH  write data.
REQ-013 re  input  1  read enable.
REQ-014 raddr  input  ADDR_WIDTH  read address.
REQ-015 rddata  output  DATA_WIDTH  registered read data.
REQ-016 rvalid  output  1  one-cycle pulse qualifying rddata.
REQ-017 addr_err  output  1  one-cycle pulse on an accepted access to an address >= DEPTH.

Function
REQ-018 The FSM SHALL have two states: CLEAR (busy=1) and IDLE (busy=0).
REQ-019 CLEAR: one word per cycle zeroed, sweep address 0 to DEPTH-1; the last word is zeroed in the DEPTH-th cycle, and the state is IDLE in the following cycle.
REQ-020 IDLE -> CLEAR on init_req=1; init_req SHALL be ignored while in CLEAR.
REQ-021 While busy=1, we and re SHALL be ignored: no array write, rvalid=0, addr_err=0, rddata held.
REQ-022 Write in IDLE with we=1 and waddr < DEPTH: only lanes with wbe[k]=1 updated at the clock edge; wbe all zero SHALL be a no-op.
REQ-023 Read in IDLE with re=1: rddata = word[raddr] and rvalid=1 in the cycle after re (latency 1).
REQ-024 With re=0, rvalid SHALL be 0 and rddata SHALL hold its last value.
REQ-025 Same-cycle we and re to the same address: RD_MODE=0 returns pre-write data; RD_MODE=1 returns the merged word (new bytes on enabled lanes, old bytes elsewhere).
REQ-026 Write to waddr >= DEPTH: dropped, addr_err=1 next cycle.
REQ-027 Read of raddr >= DEPTH: rddata=0 and rvalid=1 next cycle, with addr_err=1 in the same cycle.
REQ-028 A simultaneous write error and read error SHALL produce a single addr_err pulse.

Reset
REQ-029 rst_n=0 at a clock edge SHALL force: state=CLEAR, sweep address=0, rddata=0, rvalid=0, addr_err=0; busy=1 as a consequence of state CLEAR.
REQ-030 Reset asserted mid-sweep or mid-read SHALL restart the sweep from address 0; array contents after reset release are all-zero only once busy falls.
REQ-031 The first IDLE access SHALL be possible DEPTH cycles after rst_n rises.

Configuration
REQ-032 Macro DP_MEMORY_PARITY_EN defined: one even-parity bit is stored per byte lane, computed on write and zeroed on clear; output par_err (1 bit) pulses with rvalid when any lane read of an in-range address mismatches; par_err is reset to 0.
REQ-033 Macro absent: no parity storage, no par_err port; behaviour is otherwise identical.

Verification
REQ-034 Reset release -> busy=1 for exactly DEPTH cycles; then reading every address returns 0 with rvalid=1 one cycle after re.
REQ-035 DATA_WIDTH=16: write 0xABCD at addr 2 with wbe=11, then 0x1234 with wbe=01; read addr 2 -> 0xAB34.
REQ-036 Same-cycle write 0x55 and read of addr 5 holding 0x11: RD_MODE=0 -> 0x11; RD_MODE=1 -> 0x55.
REQ-037 DEPTH=6, ADDR_WIDTH=3: write to addr 7 -> addr_err pulse, no array change; read addr 7 -> rddata=0, rvalid=1, addr_err=1.
REQ-038 init_req pulse, then we/re during busy -> no writes, rvalid stays 0; rst_n=0 mid-sweep -> sweep restarts at 0 with full DEPTH-cycle busy.
REQ-039 DP_MEMORY_PARITY_EN: force-flip one stored data bit, read -> par_err=1 with rvalid; clean read -> par_err=0.
